wb_trace_buffer: RTL and testbench

//  Parametrised write-back retirement trace buffer for the pipelined RISC-V processor.
//  - Taps the MEM/WB stage: pc, instruction, rd, write data and rf_enable.
//  - Stores qualifying retirements in a circular buffer.
//  - Drains them over a valid/ready stream, so benches and debug logic consume a lossless, ordered record.
//  - Replaces per-cycle $monitor printing.

---
 rtl/wb_trace_pkg.sv | 58 +++++
 rtl/trace_fifo.sv | 93 +++++++++
 rtl/wb_trace_buffer.sv | 117 +++++++++++
 tb/tb_wb_trace_buffer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// ============================================================================
// Module   : wb_trace_pkg
// Purpose  : Shared constants for the write-back retirement trace buffer:
//            entry field offsets and widths, total entry width, and the x0
//            register index used by the capture filter.
// Config   : WB_TRACE_TIMESTAMP_EN - when defined, entries carry a leading
//            timestamp field of TS_W bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_trace_pkg;

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam bit c_TS_EN = 1'b1;
`else
    localparam bit c_TS_EN = 1'b0;
`endif

    // Architectural zero register; writes to it are never interesting.
    localparam logic [4:0] X0 = 5'd0;

    localparam int c_INSTR_W = 32;
    localparam int c_RD_W    = 5;

    // Entry layout, LSB first: data | rd | rf_enable | instr | pc | [ts]
    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int rd_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int rf_en_lsb(input int xlen);
        return xlen + c_RD_W;
    endfunction

    function automatic int instr_lsb(input int xlen);
        return xlen + c_RD_W + 1;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return xlen + c_RD_W + 1 + c_INSTR_W;
    endfunction

    function automatic int ts_lsb(input int xlen);
        return 2 * xlen + c_RD_W + 1 + c_INSTR_W;
    endfunction

    // TS_W contributes only when the timestamp field is compiled in.
    function automatic int entry_w(input int xlen, input int ts_w);
        return (c_TS_EN ? ts_w : 0) + 2 * xlen + c_INSTR_W + 1 + c_RD_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module   : trace_fifo
// Purpose  : DEPTH x WIDTH circular buffer with occupancy count and an
//            optional overwrite-oldest policy when full.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_push, i_data    - write request and entry
//            i_ready           - consumer accepts head
//            o_valid, o_data   - head present / head entry
//            o_count           - occupancy (0..DEPTH)
//            o_full, o_empty   - occupancy flags
//            o_drop            - a push this cycle loses an entry
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_write;
    logic w_evict;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_ready;

    // When full, a simultaneous pop frees the slot the write lands in
    // (wr_ptr == rd_ptr), so the popped head is read before it is replaced.
    assign w_write = i_push && (!w_full || w_pop || (OVERWRITE != 0));
    assign w_evict = i_push && w_full && !w_pop && (OVERWRITE != 0);
    assign o_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_write && !w_pop && !w_evict) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/wb_trace_buffer.sv
// ============================================================================
// Module   : wb_trace_buffer
// Purpose  : Retirement trace buffer tapping the MEM/WB stage. Qualifying
//            retirements are stored in a circular buffer and drained in order
//            over a valid/ready stream.
// Config   : WB_TRACE_TIMESTAMP_EN - adds a free-running TS_W cycle counter
//            and prefixes each entry with its capture-cycle value.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            enable, capture_all   - capture enable / capture every retirement
//            wb_valid, wb_pc, wb_instr, wb_rf_enable, wb_rd, wb_data
//                                  - write-back stage tap
//            out_valid, out_ready, out_entry - drain stream
//            count, overflow_cnt, full, empty - status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int TS_W      = 16,
    localparam int ENTRY_W  = entry_w(XLEN, TS_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   capture_all,
    input  logic                   wb_valid,
    input  logic [XLEN-1:0]        wb_pc,
    input  logic [31:0]            wb_instr,
    input  logic                   wb_rf_enable,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENTRY_W-1:0]     out_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            overflow_cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int c_DATA_LSB  = data_lsb();
    localparam int c_RD_LSB    = rd_lsb(XLEN);
    localparam int c_RFEN_LSB  = rf_en_lsb(XLEN);
    localparam int c_INSTR_LSB = instr_lsb(XLEN);
    localparam int c_PC_LSB    = pc_lsb(XLEN);

    logic               w_capture;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_entry;
    logic [15:0]        r_ovf;

    assign w_capture = enable && wb_valid &&
                       (capture_all || (wb_rf_enable && (wb_rd != X0)));

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int c_TS_LSB = ts_lsb(XLEN);

    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end
`endif

    always_comb begin
        w_entry                              = '0;
        w_entry[c_DATA_LSB  +: XLEN]         = wb_data;
        w_entry[c_RD_LSB    +: c_RD_W]       = wb_rd;
        w_entry[c_RFEN_LSB]                  = wb_rf_enable;
        w_entry[c_INSTR_LSB +: c_INSTR_W]    = wb_instr;
        w_entry[c_PC_LSB    +: XLEN]         = wb_pc;
`ifdef WB_TRACE_TIMESTAMP_EN
        w_entry[c_TS_LSB    +: TS_W]         = r_ts;
`endif
    end

    trace_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_capture),
        .i_data  (w_entry),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_entry),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty),
        .o_drop  (w_drop)
    );

    // Counts entries lost in either overflow policy; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 1'b1;
        end
    end

    assign overflow_cnt = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
// ============================================================================
// Module   : tb_wb_trace_buffer
// Purpose  : Self-checking bench for wb_trace_buffer. Two DEPTH=4 instances
//            (drop-new and overwrite-oldest) share one stimulus stream and
//            are compared against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int EW = TS_W + 2 * XLEN + 38;
`else
    localparam int EW = 2 * XLEN + 38;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [EW-1:0] entry_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            capture_all;
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_instr;
    logic            wb_rf_enable;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_ready;

    logic            ov     [2];
    entry_t          oe     [2];
    logic [CW-1:0]   ocnt   [2];
    logic [15:0]     oovf   [2];
    logic            ofull  [2];
    logic            oempty [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(0), .TS_W(TS_W)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .capture_all(capture_all),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_entry(oe[0]),
        .count(ocnt[0]), .overflow_cnt(oovf[0]), .full(ofull[0]), .empty(oempty[0])
    );

    wb_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(1), .TS_W(TS_W)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .capture_all(capture_all),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_entry(oe[1]),
        .count(ocnt[1]), .overflow_cnt(oovf[1]), .full(ofull[1]), .empty(oempty[1])
    );

    // ---------------- reference model (ordered queues) ----------------
    entry_t          q0[$];
    entry_t          q1[$];
    int              ovf0;
    int              ovf1;
    logic [TS_W-1:0] mts;
    bit              m_cap;
    bit              m_pop;
    bit              m_full;
    entry_t          m_e;

    function automatic entry_t mk(input logic [XLEN-1:0] pc, input logic [31:0] ins,
                                  input logic rfen, input logic [4:0] rd,
                                  input logic [XLEN-1:0] d);
`ifdef WB_TRACE_TIMESTAMP_EN
        return {mts, pc, ins, rfen, rd, d};
`else
        return {pc, ins, rfen, rd, d};
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            ovf0 = 0;
            ovf1 = 0;
            mts  = '0;
        end else begin
            m_cap = enable && wb_valid && (capture_all || (wb_rf_enable && wb_rd != 5'd0));
            m_e   = mk(wb_pc, wb_instr, wb_rf_enable, wb_rd, wb_data);
            // drop-newest policy
            m_pop  = (q0.size() != 0) && out_ready;
            m_full = (q0.size() == DEPTH);
            if (m_pop) void'(q0.pop_front());
            if (m_cap) begin
                if (!m_full || m_pop) q0.push_back(m_e);
                else if (ovf0 < 65535) ovf0++;
            end
            // overwrite-oldest policy
            m_pop  = (q1.size() != 0) && out_ready;
            m_full = (q1.size() == DEPTH);
            if (m_pop) void'(q1.pop_front());
            if (m_cap) begin
                if (!m_full || m_pop) q1.push_back(m_e);
                else begin
                    void'(q1.pop_front());
                    q1.push_back(m_e);
                    if (ovf1 < 65535) ovf1++;
                end
            end
            mts = mts + 1'b1;
        end
    end

    function automatic int exp_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic entry_t exp_head(input int k);
        if (exp_size(k) == 0) return '0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int exp_ovf(input int k);
        return (k == 0) ? ovf0 : ovf1;
    endfunction

    function automatic logic [XLEN-1:0] f_pc(input entry_t e);
        return e[2*XLEN+37 -: XLEN];
    endfunction

    function automatic logic [4:0] f_rd(input entry_t e);
        return e[XLEN+4 -: 5];
    endfunction

    function automatic logic [XLEN-1:0] f_data(input entry_t e);
        return e[XLEN-1:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid     = 1'b0;
        wb_rf_enable = 1'b0;
        wb_rd        = 5'd0;
        wb_pc        = '0;
        wb_data      = '0;
        wb_instr     = '0;
    endtask

    task automatic drive(input logic [XLEN-1:0] pc, input logic rfen,
                         input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_valid     = 1'b1;
        wb_pc        = pc;
        wb_instr     = $urandom;
        wb_rf_enable = rfen;
        wb_rd        = rd;
        wb_data      = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, ov[k]); end
            n_cmp++; if (ocnt[k] !== '0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", k, ocnt[k]); end
            n_cmp++; if (oovf[k] !== 16'd0) begin n_fail++; $display("FAIL reset_ovf[%0d]: got %0d want 0", k, oovf[k]); end
            n_cmp++; if (oempty[k] !== 1'b1) begin n_fail++; $display("FAIL reset_empty[%0d]: got %b want 1", k, oempty[k]); end
            n_cmp++; if (ofull[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d]: got %b want 0", k, ofull[k]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_filter();
        entry_t got[$];
        pulse_reset();
        enable = 1'b1; capture_all = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: drive($urandom, 1'b1, 5'd1, 32'd5);
                1: drive($urandom, 1'b1, 5'd2, 32'd7);
                2: drive($urandom, 1'b1, 5'd0, 32'd9);
                default: idle();
            endcase
            cyc();
            if (ov[0]) got.push_back(oe[0]);
        end
        n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL filter_n: got %0d entries want 2", got.size()); end
        if (got.size() >= 2) begin
            n_cmp++; if (f_rd(got[0]) !== 5'd1 || f_data(got[0]) !== 32'd5) begin n_fail++;
                $display("FAIL filter_e0: got rd=%0d data=%0d want rd=1 data=5", f_rd(got[0]), f_data(got[0])); end
            n_cmp++; if (f_rd(got[1]) !== 5'd2 || f_data(got[1]) !== 32'd7) begin n_fail++;
                $display("FAIL filter_e1: got rd=%0d data=%0d want rd=2 data=7", f_rd(got[1]), f_data(got[1])); end
        end
        n_cmp++; if (oempty[0] !== 1'b1) begin n_fail++; $display("FAIL filter_empty: got %b want 1", oempty[0]); end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] got0[$];
        logic [XLEN-1:0] got1[$];
        logic [XLEN-1:0] want0 [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
        logic [XLEN-1:0] want1 [4] = '{32'd8, 32'd12, 32'd16, 32'd20};
        pulse_reset();
        enable = 1'b1; capture_all = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(XLEN'(i * 4), 1'b1, 5'(i + 1), $urandom);
            cyc();
        end
        idle();
        cyc();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ofull[k] !== 1'b1) begin n_fail++; $display("FAIL ovf_full[%0d]: got %b want 1", k, ofull[k]); end
            n_cmp++; if (ocnt[k] !== CW'(4)) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d want 4", k, ocnt[k]); end
            n_cmp++; if (oovf[k] !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt[%0d]: got %0d want 2", k, oovf[k]); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ov[0]) got0.push_back(f_pc(oe[0]));
            if (ov[1]) got1.push_back(f_pc(oe[1]));
            cyc();
        end
        out_ready = 1'b0;
        n_cmp++; if (got0.size() != 4) begin n_fail++; $display("FAIL drop_n: got %0d want 4", got0.size()); end
        n_cmp++; if (got1.size() != 4) begin n_fail++; $display("FAIL ow_n: got %0d want 4", got1.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got0.size()) begin
                n_cmp++; if (got0[i] !== want0[i]) begin n_fail++; $display("FAIL drop_pc%0d: got %0d want %0d", i, got0[i], want0[i]); end
            end
            if (i < got1.size()) begin
                n_cmp++; if (got1[i] !== want1[i]) begin n_fail++; $display("FAIL ow_pc%0d: got %0d want %0d", i, got1[i], want1[i]); end
            end
        end
    endtask

    task automatic test_full_push_pop();
        pulse_reset();
        enable = 1'b1; capture_all = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(XLEN'(32'h100 + i * 4), 1'b0, 5'd0, $urandom);
            cyc();
        end
        drive(32'h200, 1'b1, 5'd3, $urandom);
        out_ready = 1'b1;
        cyc();
        idle();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ocnt[k] !== CW'(4)) begin n_fail++; $display("FAIL fpp_count[%0d]: got %0d want 4", k, ocnt[k]); end
            n_cmp++; if (oovf[k] !== 16'd0) begin n_fail++; $display("FAIL fpp_ovf[%0d]: got %0d want 0", k, oovf[k]); end
            n_cmp++; if (f_pc(oe[k]) !== 32'h104) begin n_fail++; $display("FAIL fpp_head[%0d]: got %h want 104", k, f_pc(oe[k])); end
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        enable = 1'b1; capture_all = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 1'b1, 5'd4, $urandom);
            cyc();
        end
        idle();
        n_cmp++; if (ocnt[0] !== CW'(2)) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 2", ocnt[0]); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL mid_valid[%0d]: got %b want 0", k, ov[k]); end
            n_cmp++; if (ocnt[k] !== '0) begin n_fail++; $display("FAIL mid_count[%0d]: got %0d want 0", k, ocnt[k]); end
            n_cmp++; if (oovf[k] !== 16'd0) begin n_fail++; $display("FAIL mid_ovf[%0d]: got %0d want 0", k, oovf[k]); end
        end
    endtask

    task automatic test_enable();
        int popped = 0;
        pulse_reset();
        enable = 1'b1; capture_all = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'b1, 5'd6, $urandom);
            cyc();
        end
        enable = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive($urandom, 1'b1, 5'd7, $urandom);
            if (ov[0]) popped++;
            cyc();
        end
        idle();
        enable = 1'b1;
        out_ready = 1'b0;
        n_cmp++; if (popped != 3) begin n_fail++; $display("FAIL en_popped: got %0d want 3", popped); end
        n_cmp++; if (ocnt[0] !== '0) begin n_fail++; $display("FAIL en_count: got %0d want 0", ocnt[0]); end
        n_cmp++; if (oovf[1] !== 16'd0) begin n_fail++; $display("FAIL en_ovf: got %0d want 0", oovf[1]); end
    endtask

`ifdef WB_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        entry_t got[$];
        logic [TS_W-1:0] d;
        pulse_reset();
        enable = 1'b1; capture_all = 1'b1; out_ready = 1'b0;
        drive($urandom, 1'b1, 5'd1, $urandom); cyc();
        idle(); cyc(); cyc();
        drive($urandom, 1'b1, 5'd2, $urandom); cyc();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ov[0]) got.push_back(oe[0]);
            cyc();
        end
        out_ready = 1'b0;
        n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL ts_n: got %0d want 2", got.size()); end
        if (got.size() == 2) begin
            d = got[1][EW-1 -: TS_W] - got[0][EW-1 -: TS_W];
            n_cmp++; if (d !== TS_W'(3)) begin n_fail++; $display("FAIL ts_delta: got %0d want 3", d); end
        end
    endtask
`endif

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            capture_all  = $urandom_range(0, 1);
            wb_valid     = ($urandom_range(0, 9) < 7);
            wb_pc        = $urandom;
            wb_instr     = $urandom;
            wb_rf_enable = $urandom_range(0, 1);
            wb_rd        = 5'($urandom_range(0, 3));
            wb_data      = $urandom;
            // alternate slow and fast consumer phases to reach full and empty
            out_ready    = ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (ov[k] !== (exp_size(k) != 0)) begin n_fail++;
                    $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", k, c, ov[k], exp_size(k) != 0); end
                n_cmp++; if (ocnt[k] !== CW'(exp_size(k))) begin n_fail++;
                    $display("FAIL rnd_count[%0d] c%0d: got %0d want %0d", k, c, ocnt[k], exp_size(k)); end
                n_cmp++; if (ofull[k] !== (exp_size(k) == DEPTH) || oempty[k] !== (exp_size(k) == 0)) begin n_fail++;
                    $display("FAIL rnd_flags[%0d] c%0d: got full=%b empty=%b want size %0d", k, c, ofull[k], oempty[k], exp_size(k)); end
                n_cmp++; if (oovf[k] !== 16'(exp_ovf(k))) begin n_fail++;
                    $display("FAIL rnd_ovf[%0d] c%0d: got %0d want %0d", k, c, oovf[k], exp_ovf(k)); end
                if (exp_size(k) != 0) begin
                    n_cmp++; if (oe[k] !== exp_head(k)) begin n_fail++;
                        $display("FAIL rnd_head[%0d] c%0d: got %h want %h", k, c, oe[k], exp_head(k)); end
                end
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; capture_all = 1'b0; out_ready = 1'b0;
        idle();
        cyc();
        test_reset();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_enable();
`ifdef WB_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
